branch_hazard_unit: RTL and testbench
=====================================

BRANCH_HAZARD_UNIT -- requirements
Module: branch_hazard_unit

Interface
REQ-001 Parameter: REG_W, 4, register-index width (16 architectural registers, r0 hardwired zero).
REQ-002 Parameter: CNT_W, 16, stall-event counter width.
REQ-003 Port: clk  in  1  single clock, all state on rising edge.
REQ-004 Port: rst  in  1  asynchronous, active-high reset.
REQ-005 Port: hold  in  1  global pipeline freeze; all trackers and counter hold.
REQ-006 Port: flush  in  1  squash the instruction currently in ID (branch taken).
REQ-007 Port: id_valid  in  1  ID slot holds a real instruction.
REQ-008 Port: id_is_branch  in  1  ID instruction is a branch reading rs1/rs2 in ID.
REQ-009 Port: id_rs1, id_rs2  in  REG_W  branch source registers.
REQ-010 Port: id_wr_en, id_is_load  in  1  ID instruction writes a register / is a load.
REQ-011 Port: id_rd  in  REG_W  ID destination register.
REQ-012 Port: forward_c  out  4  [1:0] rs1 select, [3:2] rs2 select: 00 regfile, 01 EX ALU, 10 EX/MEM ALU, 11 WB data.
REQ-013 Port: stall  out  1  hold PC and IF/ID, inject bubble into EX.
REQ-014 Port: stall_events  out  CNT_W  count of distinct stall episodes.

Function
REQ-015 Three tracker slots (EX, MEM, WB), each {valid, wr_en, rd, is_load}, shall advance ID->EX->MEM->WB on every clock edge with hold=0.
REQ-016 On stall=1 or flush=1 (hold=0), EX slot shall load a bubble (valid=0); MEM and WB shall still advance.
REQ-017 A slot matches operand rsN when valid & wr_en & rd==rsN & rsN!=0.
REQ-018 forward_c shall be combinational from ID inputs and slot state (zero latency) and 00 whenever id_valid & id_is_branch is 0.
REQ-019 Per operand, priority youngest-first: EX match non-load -> 01; else MEM match non-load -> 10; else WB match -> 11; else 00.
REQ-020 stall shall assert when a branch operand matches a load in EX (two stall cycles result) or a load in MEM (one stall cycle).
REQ-021 While stall=1, forward_c shall still be driven per REQ-019 ignoring load slots; consumer discards the value.
REQ-022 flush=1 shall suppress stall in the same cycle (squashed instruction creates no hazard).
REQ-023 FSM states RUN, STALL: RUN->STALL when stall=1; STALL->RUN when stall=0; hold=1 freezes the state.
REQ-024 stall_events shall increment by 1 on each RUN->STALL transition and wrap modulo 2^CNT_W.
REQ-025 hold=1 shall take precedence over stall and flush: no slot, FSM or counter update.

Reset
REQ-026 rst=1 shall asynchronously clear all slot valid/wr_en/is_load bits, rd fields, FSM to RUN, stall_events to 0.
REQ-027 During and after reset with id_valid=0: forward_c=0000, stall=0.
REQ-028 Reset mid-stall shall abandon the stall; first post-reset cycle is RUN with no tracked hazards.

Structure
REQ-029 Forwarding encodings (00/01/10/11) and FSM state encodings shall live in a shared package, also used by the branch operand selector.
REQ-030 One sub-module, hazard_slot, shall implement a single tracker slot (register + match compare), instantiated three times.

Verification
REQ-031 add r3 then beq r3,r4 next cycle -> forward_c=0001, stall=0.
REQ-032 add r5; nop; beq r1,r5 -> forward_c=1000; with two nops -> 1100.
REQ-033 lw r2 then beq r2,r2 -> stall=1 two cycles, then forward_c=1111, stall_events=1.
REQ-034 add r0 then beq r0,r0 -> forward_c=0000; same hazard with flush=1 -> stall=0, EX bubble.
REQ-035 Assert rst during second cycle of a load stall -> stall=0, forward_c=0000 immediately, counter=0.
REQ-036 Force counter to 0xFFFF, trigger a stall episode -> stall_events=0x0000; hold=1 during stall -> all outputs frozen.

Source files
------------

// File: rtl/branch_hazard_pkg.sv
// Shared encodings for branch operand forwarding and hazard FSM.
// Used by the hazard unit and the ID-stage branch operand selector.
package branch_hazard_pkg;

    typedef enum logic [1:0] {
        FWD_RF  = 2'b00,
        FWD_EX  = 2'b01,
        FWD_MEM = 2'b10,
        FWD_WB  = 2'b11
    } fwd_e;

    typedef enum logic {
        ST_RUN   = 1'b0,
        ST_STALL = 1'b1
    } hz_state_e;

    // Youngest producer wins; callers pass only non-load hits for EX/MEM.
    function automatic fwd_e fwd_pick(
        input logic ex_hit,
        input logic mem_hit,
        input logic wb_hit
    );
        fwd_e sel;
        sel = FWD_RF;
        priority case (1'b1)
            ex_hit:  sel = FWD_EX;
            mem_hit: sel = FWD_MEM;
            wb_hit:  sel = FWD_WB;
            default: sel = FWD_RF;
        endcase
        return sel;
    endfunction

endpackage

// File: rtl/branch_hazard_unit_slot.sv
// One pipeline tracker slot: destination info register plus
// operand match against the branch sources in ID.
module hazard_slot
    import branch_hazard_pkg::*;
#(
    parameter int REG_W = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             adv,
    input  logic [REG_W+2:0] d,
    input  logic [REG_W-1:0] rs1,
    input  logic [REG_W-1:0] rs2,
    output logic [REG_W+2:0] q,
    output logic             fwd1,
    output logic             fwd2,
    output logic             ld1,
    output logic             ld2
);

    logic             valid;
    logic             wr_en;
    logic             is_load;
    logic [REG_W-1:0] rd;
    logic             m1;
    logic             m2;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            valid   <= 1'b0;
            wr_en   <= 1'b0;
            is_load <= 1'b0;
            rd      <= '0;
        end else if (adv) begin
            {valid, wr_en, is_load, rd} <= d;
        end
    end

    assign q = {valid, wr_en, is_load, rd};

    assign m1 = valid & wr_en & (rd == rs1) & (|rs1);
    assign m2 = valid & wr_en & (rd == rs2) & (|rs2);

    assign fwd1 = m1 & ~is_load;
    assign fwd2 = m2 & ~is_load;
    assign ld1  = m1 & is_load;
    assign ld2  = m2 & is_load;

endmodule

// File: rtl/branch_hazard_unit.sv
// Branch operand forwarding and load-use stall detection for ID-stage
// branch resolution, with a stall-episode counter.
module branch_hazard_unit
    import branch_hazard_pkg::*;
#(
    parameter int REG_W = 4,
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             hold,
    input  logic             flush,
    input  logic             id_valid,
    input  logic             id_is_branch,
    input  logic [REG_W-1:0] id_rs1,
    input  logic [REG_W-1:0] id_rs2,
    input  logic             id_wr_en,
    input  logic             id_is_load,
    input  logic [REG_W-1:0] id_rd,
    output logic [3:0]       forward_c,
    output logic             stall,
    output logic [CNT_W-1:0] stall_events
);

    localparam int SW = REG_W + 3;

    logic [SW-1:0] chain [4];
    logic [2:0]    fh1;
    logic [2:0]    fh2;
    logic [2:0]    lh1;
    logic [2:0]    lh2;
    logic          live;
    fwd_e          sel1;
    fwd_e          sel2;
    hz_state_e     state_q;
    hz_state_e     state_d;
    logic          cnt_inc;
    logic [CNT_W-1:0] cnt_q;

    assign live = id_valid & id_is_branch;

    assign stall = live & ~flush & (lh1[0] | lh2[0] | lh1[1] | lh2[1]);

    // A squashed or stalled ID instruction enters EX as a bubble.
    assign chain[0] = (stall | flush) ? '0
                    : {id_valid, id_wr_en, id_is_load, id_rd};

    for (genvar i = 0; i < 3; i++) begin : g_slot
        hazard_slot #(.REG_W(REG_W)) u_slot (
            .clk  (clk),
            .rst  (rst),
            .adv  (~hold),
            .d    (chain[i]),
            .rs1  (id_rs1),
            .rs2  (id_rs2),
            .q    (chain[i+1]),
            .fwd1 (fh1[i]),
            .fwd2 (fh2[i]),
            .ld1  (lh1[i]),
            .ld2  (lh2[i])
        );
    end

    assign sel1 = fwd_pick(fh1[0], fh1[1], fh1[2] | lh1[2]);
    assign sel2 = fwd_pick(fh2[0], fh2[1], fh2[2] | lh2[2]);

    assign forward_c = live ? {sel2, sel1} : 4'b0000;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= ST_RUN;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            if (cnt_inc)
                cnt_q <= cnt_q + 1'b1;
        end
    end

    always_comb begin
        state_d = state_q;
        cnt_inc = 1'b0;
        if (!hold) begin
            unique case (state_q)
                ST_RUN: begin
                    if (stall) begin
                        state_d = ST_STALL;
                        cnt_inc = 1'b1;
                    end
                end
                ST_STALL: begin
                    if (!stall)
                        state_d = ST_RUN;
                end
                default: state_d = ST_RUN;
            endcase
        end
    end

    assign stall_events = cnt_q;

endmodule

// File: tb/tb_branch_hazard_unit.sv
// Scoreboard bench for branch_hazard_unit: reference pipeline model
// feeds an expectation queue drained by an independent monitor.
module tb_branch_hazard_unit;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       hold = 1'b0;
    logic       flush = 1'b0;
    logic       id_valid = 1'b0;
    logic       id_is_branch = 1'b0;
    logic [3:0] id_rs1 = '0;
    logic [3:0] id_rs2 = '0;
    logic       id_wr_en = 1'b0;
    logic       id_is_load = 1'b0;
    logic [3:0] id_rd = '0;

    logic [3:0]  fwd_a;
    logic        stall_a;
    logic [15:0] ev_a;
    logic [3:0]  fwd_b;
    logic        stall_b;
    logic [3:0]  ev_b;

    always #5 clk = ~clk;

    branch_hazard_unit dut (
        .clk(clk), .rst(rst), .hold(hold), .flush(flush),
        .id_valid(id_valid), .id_is_branch(id_is_branch),
        .id_rs1(id_rs1), .id_rs2(id_rs2),
        .id_wr_en(id_wr_en), .id_is_load(id_is_load), .id_rd(id_rd),
        .forward_c(fwd_a), .stall(stall_a), .stall_events(ev_a)
    );

    // Narrow counter instance exposes wrap-around within a short run.
    branch_hazard_unit #(.REG_W(4), .CNT_W(4)) dut_w (
        .clk(clk), .rst(rst), .hold(hold), .flush(flush),
        .id_valid(id_valid), .id_is_branch(id_is_branch),
        .id_rs1(id_rs1), .id_rs2(id_rs2),
        .id_wr_en(id_wr_en), .id_is_load(id_is_load), .id_rd(id_rd),
        .forward_c(fwd_b), .stall(stall_b), .stall_events(ev_b)
    );

    typedef struct {
        bit       v;
        bit       br;
        bit [3:0] rs1;
        bit [3:0] rs2;
        bit       we;
        bit       ld;
        bit [3:0] rd;
    } instr_t;

    typedef struct {
        bit [3:0]  fwd;
        bit        stall;
        bit [15:0] ev16;
        bit [3:0]  ev4;
        int        tag;
    } exp_t;

    exp_t exp_q [$];
    int checks = 0;
    int failures = 0;
    int tag = 0;

    // Model: pipe[0]=EX, pipe[1]=MEM, pipe[2]=WB (age of producer).
    instr_t      pipe [3];
    bit          in_episode;
    int unsigned episodes;
    bit          last_stall;

    function automatic instr_t mk(bit v, bit br, int a, int b,
                                  bit we, bit ld, int rd);
        instr_t t;
        t.v = v; t.br = br; t.rs1 = 4'(a); t.rs2 = 4'(b);
        t.we = we; t.ld = ld; t.rd = 4'(rd);
        return t;
    endfunction

    function automatic bit writes(int age, bit [3:0] r);
        return pipe[age].v && pipe[age].we && pipe[age].rd == r && r != 0;
    endfunction

    function automatic bit [1:0] src_of(bit [3:0] r);
        for (int age = 0; age < 3; age++) begin
            if (writes(age, r)) begin
                if (age == 2)
                    return 2'd3;
                if (!pipe[age].ld)
                    return 2'(age + 1);
            end
        end
        return 2'd0;
    endfunction

    function automatic bit load_pending(bit [3:0] r);
        return (writes(0, r) && pipe[0].ld) || (writes(1, r) && pipe[1].ld);
    endfunction

    task automatic model_reset();
        for (int i = 0; i < 3; i++)
            pipe[i] = mk(0, 0, 0, 0, 0, 0, 0);
        in_episode = 0;
        episodes = 0;
    endtask

    task automatic step(instr_t ins, bit fl, bit hd, bit rs);
        exp_t   e;
        bit     live;
        instr_t nxt;
        @(negedge clk);
        rst = rs; hold = hd; flush = fl;
        id_valid = ins.v; id_is_branch = ins.br;
        id_rs1 = ins.rs1; id_rs2 = ins.rs2;
        id_wr_en = ins.we; id_is_load = ins.ld; id_rd = ins.rd;
        if (rs)
            model_reset();
        live = ins.v && ins.br;
        e.fwd = live ? {src_of(ins.rs2), src_of(ins.rs1)} : 4'b0;
        e.stall = !rs && live && !fl
                  && (load_pending(ins.rs1) || load_pending(ins.rs2));
        e.ev16 = 16'(episodes);
        e.ev4 = 4'(episodes);
        e.tag = tag++;
        exp_q.push_back(e);
        last_stall = e.stall;
        if (!rs && !hd) begin
            nxt = (e.stall || fl) ? mk(0, 0, 0, 0, 0, 0, 0) : ins;
            pipe[2] = pipe[1];
            pipe[1] = pipe[0];
            pipe[0] = nxt;
            if (e.stall && !in_episode)
                episodes++;
            in_episode = e.stall;
        end
    endtask

    // Issue an instruction, re-presenting it while the model says stall.
    task automatic issue(instr_t ins);
        int n = 0;
        step(ins, 0, 0, 0);
        while (last_stall && n < 8) begin
            step(ins, 0, 0, 0);
            n++;
        end
        if (last_stall) begin
            checks++;
            failures++;
            $display("FAIL issue_timeout: stall still 1 after 8 cycles, required 0");
        end
    endtask

    always @(negedge clk) begin
        exp_t e;
        #2;
        if (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            checks++;
            if (fwd_a !== e.fwd || stall_a !== e.stall || ev_a !== e.ev16
                || fwd_b !== e.fwd || stall_b !== e.stall || ev_b !== e.ev4) begin
                failures++;
                $display("FAIL cycle%0d: got fwd=%b stall=%b ev=%h fwd_w=%b stall_w=%b ev_w=%h required fwd=%b stall=%b ev=%h ev_w=%h",
                         e.tag, fwd_a, stall_a, ev_a, fwd_b, stall_b, ev_b,
                         e.fwd, e.stall, e.ev16, e.ev4);
            end
        end
    end

    instr_t nop;

    initial begin
        model_reset();
        nop = mk(0, 0, 0, 0, 0, 0, 0);
        step(nop, 0, 0, 1);
        step(nop, 0, 0, 1);
        step(nop, 0, 0, 0);

        issue(mk(1, 0, 0, 0, 1, 0, 3));
        issue(mk(1, 1, 3, 4, 0, 0, 0));

        issue(mk(1, 0, 0, 0, 1, 0, 5));
        issue(nop);
        issue(mk(1, 1, 1, 5, 0, 0, 0));
        issue(mk(1, 0, 0, 0, 1, 0, 5));
        issue(nop);
        issue(nop);
        issue(mk(1, 1, 1, 5, 0, 0, 0));

        issue(mk(1, 0, 0, 0, 1, 1, 2));
        issue(mk(1, 1, 2, 2, 0, 0, 0));

        issue(mk(1, 0, 0, 0, 1, 0, 0));
        issue(mk(1, 1, 0, 0, 0, 0, 0));
        issue(mk(1, 0, 0, 0, 1, 1, 6));
        step(mk(1, 1, 6, 1, 0, 0, 0), 1, 0, 0);
        issue(mk(1, 1, 6, 6, 0, 0, 0));

        issue(mk(1, 0, 0, 0, 1, 1, 7));
        step(mk(1, 1, 7, 0, 0, 0, 0), 0, 0, 0);
        step(mk(1, 1, 7, 0, 0, 0, 0), 0, 0, 1);
        step(mk(1, 1, 7, 0, 0, 0, 0), 0, 0, 0);

        // Enough load-use episodes to wrap the narrow counter, with holds.
        for (int k = 0; k < 18; k++) begin
            issue(mk(1, 0, 0, 0, 1, 1, 9));
            step(mk(1, 1, 9, 9, 0, 0, 0), 0, 0, 0);
            step(mk(1, 1, 9, 9, 0, 0, 0), 0, 1, 0);
            step(mk(1, 1, 9, 9, 0, 0, 0), 0, 1, 0);
            issue(mk(1, 1, 9, 9, 0, 0, 0));
        end

        for (int k = 0; k < 3000; k++) begin
            instr_t r;
            r = mk($urandom_range(0, 99) < 85, $urandom_range(0, 1),
                   $urandom_range(0, 3), $urandom_range(0, 3),
                   $urandom_range(0, 9) < 7, $urandom_range(0, 9) < 4,
                   $urandom_range(0, 3));
            step(r, $urandom_range(0, 7) == 0, $urandom_range(0, 9) == 0,
                 $urandom_range(0, 99) == 0);
        end

        @(negedge clk);
        @(negedge clk);
        #3;
        checks++;
        if (exp_q.size() != 0) begin
            failures++;
            $display("FAIL drain: %0d entries left, required 0", exp_q.size());
        end
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
